seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned restoring divider: computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. Each iteration performs one trial subtraction, built as a ripple subtractor from the team's full-adder cells using inverted divisor and carry-in 1. It sits beside the 4-bit adders in the arithmetic datapath as their inverse operation and uses a start/busy/done handshake toward the controlling sequencer.

## Interface
- WIDTH, 4, operand, quotient and remainder width (≥2)
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when the block can accept
- a  in  WIDTH  dividend, sampled on the accepting edge
- b  in  WIDTH  divisor, sampled on the accepting edge
- busy  out  1  high while iterating (RUN state)
- done  out  1  one-cycle pulse; q/r/div_zero valid from this cycle
- q  out  WIDTH  quotient, registered
- r  out  WIDTH  remainder, registered
- div_zero  out  1  set with done when b was 0

## Operation
- States: IDLE, RUN, DONE. Reset and power-up go to IDLE.
- Reset values: busy=0, done=0, q=0, r=0, div_zero=0. Internal counter and working registers are cleared.
- Accept: start=1 on an edge while in IDLE or DONE. In RUN, start is ignored, with no queuing.
- On accept with b≠0:
  - load rem=0, quo=a, div=b, cnt=WIDTH.
  - go to RUN.
- On accept with b=0:
  - go directly to DONE.
  - q=all ones, r=a, div_zero=1.
- RUN iteration, each edge:
  - {rem,quo} shifted left 1. The MSB of quo enters the rem LSB.
  - trial = shifted rem − div, computed at WIDTH+1 bits.
  - No borrow (carry-out 1): rem=trial, quo LSB=1.
  - Otherwise: rem keeps the shifted value, quo LSB=0.
  - cnt decrements.
- After the WIDTH-th iteration, go to DONE and load q=quo, r=rem, div_zero=0.
- DONE lasts exactly one cycle. Next state is RUN (or DONE for b=0) on a new accept, else IDLE.
- q, r and div_zero change only on the edge entering DONE. They hold through IDLE and RUN until the next result.
- Result invariant for b≠0: a = q·b + r, with r < b.
- Reset mid-operation: rst wins over all events on that edge. State goes to IDLE, all outputs go to reset values, and no done is produced for the aborted request.

## Timing
- Edge 0 samples start. busy=1 from edge 0 to edge WIDTH.
- done=1 between edges WIDTH and WIDTH+1, with busy=0 during that cycle.
- Latency from the start edge to done: WIDTH+1 cycles for b≠0, 1 cycle for b=0.
- Back-to-back: start held during DONE is accepted. Sustained throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- Outputs are driven from registers only, with no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, a=13, b=3, single start pulse:
  - busy high for 4 cycles.
  - done pulses on the 5th cycle with q=4, r=1, div_zero=0.
- a=7, b=0:
  - done in the cycle after the start edge.
  - q=15, r=7, div_zero=1. busy is never asserted.
- a=5, b=9 → q=0, r=5. Then a=15, b=1 with start held through DONE → second done exactly 5 cycles after the first, with q=15, r=0.
- Start a=12, b=5, then pulse start with a=9, b=2 on cycle 2 of RUN:
  - the second request is ignored.
  - result is q=2, r=2, and only one done pulse occurs.
- Start a=14, b=3, then assert rst on cycle 3 of RUN:
  - the next cycle shows busy=0, done=0, q=0, r=0.
  - no done follows.
  - a fresh request a=14, b=3 then yields q=4, r=2.
- Exhaustive sweep of all 256 (a,b) pairs against a reference model:
  - check q, r, div_zero and latency.
  - check that q/r stay stable between done pulses.

Source files
------------

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; results held until the next completion.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] rem, quo, div;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic [WIDTH:0]   shifted, div_n, trial;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;
    logic             unused_trial_msb;

    function automatic logic [1:0] full_add(
        input logic x,
        input logic y,
        input logic ci
    );
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(1));

    // Trial subtraction: shifted + ~div + 1, carry-out 1 means no borrow
    assign shifted = {rem, quo[WIDTH-1]};
    assign div_n   = ~{1'b0, div};

    always_comb begin : ripple
        logic c;
        c     = 1'b1;
        trial = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            {c, trial[i]} = full_add(shifted[i], div_n[i], c);
        end
        no_borrow = c;
    end

    assign unused_trial_msb = trial[WIDTH];
    assign rem_nxt = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (b == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            quo      <= '0;
            div      <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            if (b == '0) begin
                q        <= '1;
                r        <= a;
                div_zero <= 1'b1;
            end else begin
                rem <= '0;
                quo <= a;
                div <= b;
                cnt <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CW'(1);
            if (last) begin
                q        <= quo_nxt;
                r        <= rem_nxt;
                div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks for seq_divider at WIDTH=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] q, r;

    int nchecks = 0;
    int nerrors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .q(q),
        .r(r),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_op(
        input logic [W-1:0] ai,
        input logic [W-1:0] bi,
        input logic [W-1:0] eq,
        input logic [W-1:0] er,
        input logic         edz,
        input string        name
    );
        int lat, bcnt, both, stable;
        logic [W-1:0] q0, r0;
        @(negedge clk);
        q0 = q;
        r0 = r;
        a = ai;
        b = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        both = 0;
        stable = 1;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (q != q0 || r != r0) stable = 0;
            @(negedge clk);
            lat++;
        end
        if (busy && done) both = 1;
        chk({name, " latency"}, lat, (bi == 0) ? 1 : W + 1);
        chk({name, " busy_cycles"}, bcnt, (bi == 0) ? 0 : W);
        chk({name, " q"}, int'(q), int'(eq));
        chk({name, " r"}, int'(r), int'(er));
        chk({name, " div_zero"}, int'(div_zero), int'(edz));
        chk({name, " busy_and_done"}, both, 0);
        chk({name, " stable"}, stable, 1);
    endtask

    vec_t vecs[8];

    initial begin
        int lat, ndone;
        vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0};
        vecs[1] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1};
        vecs[2] = '{a: 4'd5,  b: 4'd9,  q: 4'd0,  r: 4'd5, dz: 1'b0};
        vecs[3] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0};
        vecs[4] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0};
        vecs[5] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, dz: 1'b1};
        vecs[7] = '{a: 4'd8,  b: 4'd2,  q: 4'd4,  r: 4'd0, dz: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset q", int'(q), 0);
        chk("reset r", int'(r), 0);
        chk("reset div_zero", int'(div_zero), 0);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
                  $sformatf("vec%0d", i));
        end

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        a = 4'd5;
        b = 4'd9;
        start = 1'b1;
        @(negedge clk);
        a = 4'd15;
        b = 4'd1;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b first latency", lat, W + 1);
        chk("b2b first q", int'(q), 0);
        chk("b2b first r", int'(r), 5);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b spacing", lat, W + 1);
        chk("b2b second q", int'(q), 15);
        chk("b2b second r", int'(r), 0);

        // Start during RUN is ignored
        @(negedge clk);
        a = 4'd12;
        b = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        @(negedge clk);
        a = 4'd9;
        b = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done) begin
                ndone++;
                chk("ignore q", int'(q), 2);
                chk("ignore r", int'(r), 2);
            end
            @(negedge clk);
        end
        chk("ignore done_count", ndone, 1);

        // Reset mid-operation aborts without a done
        @(negedge clk);
        a = 4'd14;
        b = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort q", int'(q), 0);
        chk("abort r", int'(r), 0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort no_done", ndone, 0);
        do_op(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, "after_abort");

        // Exhaustive sweep against a reference model
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                if (bi == 0) begin
                    do_op(W'(ai), W'(bi), 4'd15, W'(ai), 1'b1,
                          $sformatf("sweep %0d/%0d", ai, bi));
                end else begin
                    do_op(W'(ai), W'(bi), W'(ai / bi), W'(ai % bi), 1'b0,
                          $sformatf("sweep %0d/%0d", ai, bi));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
